mult_bus_if: RTL and testbench
==============================

Name: mult_bus_if

Overview:
- Memory-mapped front end for the shift-add multiplier core mult_32, on the femtoRV peripheral bus.
- Upstream of the core: latches operands written by the CPU, issues the start pulse, and waits for the core's done.
- Downstream of the core: captures the product and exposes status, result and an interrupt back to the CPU.
- Adds busy lockout, a watchdog timeout and sticky W1C status flags.

Parameters:
- WIDTH, 16, operand width; the product is 2*WIDTH bits.
- TIMEOUT, 64, maximum WAIT cycles before the error flag is raised.
- GUARD, 2, initial WAIT cycles during which mult_done is ignored.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- cs  in  1  peripheral select.
- rd  in  1  read strobe, qualified by cs.
- wr  in  1  write strobe, qualified by cs.
- addr  in  2  word offset: 0=A, 1=B, 2=CTRL/STATUS, 3=RESULT.
- d_in  in  32  write data.
- d_out  out  32  read data, registered.
- mult_a  out  WIDTH  operand A to the core.
- mult_b  out  WIDTH  operand B to the core.
- mult_init  out  1  start pulse to the core.
- mult_pp  in  2*WIDTH  product from the core.
- mult_done  in  1  done level from the core.
- irq  out  1  interrupt request.

Behaviour:
- Reset (asynchronous): all registers cleared. d_out=0, mult_a=0, mult_b=0, mult_init=0, irq=0. FSM goes to IDLE; busy, done, err and ie are 0; result is 0.
- Registers:
  - A (offset 0) and B (offset 1): R/W, low WIDTH bits. Reads zero-extend.
  - CTRL write (offset 2): bit0 start (self-clearing); bit1 clears done; bit2 clears err; bit3 writes ie.
  - STATUS read (offset 2): {28'b0, ie, err, done, busy}.
  - RESULT (offset 3): read-only, 2*WIDTH bits. Writes are ignored.
- Read timing: d_out updates on the clock edge that samples cs&rd and holds until the next read. Latency is 1 cycle.
- mult_a/mult_b are driven directly from the A/B registers.
- FSM:
  - IDLE: a write to CTRL with start=1 clears done and err, sets busy, and goes to START.
  - START: mult_init=1 for exactly one cycle. Clear the wait counter. Go to WAIT.
  - WAIT: increment the counter every cycle.
    - If counter>=GUARD and mult_done=1, go to CAPTURE.
    - Else if counter==TIMEOUT-1, set err, clear busy, set result=0, go to IDLE.
  - CAPTURE: result<=mult_pp, set done, clear busy, go to IDLE.
- While busy=1, writes to A, B and the start bit are ignored. Clear bits and ie writes are still honoured.
- The counter is $clog2(TIMEOUT)+1 bits and saturates; it never wraps.
- irq = ie & (done | err), registered.
- Simultaneous events:
  - Start and a done-clear in the same CTRL write: the start wins, so done ends up 0.
  - Capture and a done-clear in the same cycle: the capture wins, so done=1.
  - A read of RESULT in the CAPTURE cycle returns the old result.
- Reset mid-operation aborts immediately. mult_init drops asynchronously, and no flag survives.
- A/B are write-only-while-idle operands; arithmetic is the core's. This block does no arithmetic.

Decomposition:
- Shared package mult_pkg holds:
  - address constants ADDR_A=2'd0, ADDR_B=2'd1, ADDR_CTRL=2'd2, ADDR_RES=2'd3;
  - CTRL/STATUS bit indices;
  - FSM state encoding IDLE/START/WAIT/CAPTURE (2 bits).
- One natural sub-module: mult_watchdog, holding the WAIT counter with its GUARD-reached and TIMEOUT-reached flags.
- Everything else stays flat.

Test Plan:
- Write A=3, B=5, CTRL=0x9 (ie+start); the core model returns 15 after 20 cycles. Expect mult_init high for exactly 1 cycle, STATUS=0x0A (ie, done), RESULT=15, irq=1.
- A=0xFFFF, B=0xFFFF, start. Expect RESULT=0xFFFE0001 and done=1. Then write CTRL=0x2: done=0, irq=0.
- During busy: write A=7 and CTRL start=1. Expect A to read back unchanged, no second mult_init pulse, and the result to reflect the original operands.
- Hold mult_done=0 after start. Exactly TIMEOUT cycles after START, expect err=1, busy=0, RESULT=0. Write CTRL=0x4 and expect err=0.
- Model mult_done stale-high for 1 cycle after init. Expect it to be ignored (GUARD), with capture only on the true done.
- Assert rst 5 cycles into WAIT. Expect all outputs 0 asynchronously and STATUS=0 after release. A new start then completes normally.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier bus front end.
// Contents: bus widths, register offsets, CTRL/STATUS bit indices,
// the front-end FSM state encoding and a STATUS packing helper.
package mult_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 2;

    // Register word offsets
    localparam logic [ADDR_W-1:0] ADDR_A    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_B    = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_CTRL = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_RES  = 2'd3;

    // CTRL write bits
    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_CLR_DONE = 1;
    localparam int unsigned CTRL_CLR_ERR  = 2;
    localparam int unsigned CTRL_IE       = 3;

    // STATUS read bits
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_ERR  = 2;
    localparam int unsigned STAT_IE   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // STATUS word: {28'b0, ie, err, done, busy}
    function automatic logic [BUS_W-1:0] pack_status(input logic ie, input logic err,
                                                     input logic done, input logic busy);
        return BUS_W'({ie, err, done, busy});
    endfunction

endpackage

// File: rtl/mult_bus_if_if.sv
// CPU-side peripheral bus of the multiplier front end.
// Signals: cs (select), rd/wr (strobes), addr (word offset),
//          d_in (write data), d_out (registered read data).
// master = CPU side, slave = peripheral side.
interface mult_bus_if_if;
    import mult_pkg::*;

    logic              cs;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [BUS_W-1:0]  d_in;
    logic [BUS_W-1:0]  d_out;

    modport master (output cs, rd, wr, addr, d_in, input d_out);
    modport slave  (input cs, rd, wr, addr, d_in, output d_out);

endinterface

// File: rtl/mult_watchdog.sv
// WAIT-phase cycle counter for the multiplier front end.
// Ports: i_clear restarts the count, i_run advances it (saturating),
//        o_guard_c = count has reached GUARD,
//        o_expired_c = count is at TIMEOUT-1 (last permitted WAIT cycle).
module mult_watchdog #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned GUARD   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_guard_c,
    output logic o_expired_c
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] r_cnt;

    // Saturating counter: holds at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && (r_cnt != {CW{1'b1}})) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_guard_c   = (r_cnt >= CW'(GUARD));
    assign o_expired_c = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mult_bus_if.sv
// Memory-mapped front end for the mult_32 shift-add multiplier core.
// Ports: clk, rst (async, active-high); bus (slave modport: cs/rd/wr/addr/
//        d_in/d_out); mult_a/mult_b operands, mult_init start pulse,
//        mult_pp/mult_done from the core; irq = ie & (done | err), registered.
module mult_bus_if
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned GUARD   = 2
) (
    input  logic               clk,
    input  logic               rst,
    mult_bus_if_if.slave       bus,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    output logic               mult_init,
    input  logic [2*WIDTH-1:0] mult_pp,
    input  logic               mult_done,
    output logic               irq
);

    localparam int unsigned PW = 2 * WIDTH;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [PW-1:0]    r_result;
    logic [BUS_W-1:0] r_dout;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_ie;
    logic             r_init;
    logic             r_irq;

    logic w_wr;
    logic w_rd;
    logic w_ctrl_wr;
    logic w_guard_c;
    logic w_expired_c;
    logic w_unused_ok;

    assign w_wr      = bus.cs & bus.wr;
    assign w_rd      = bus.cs & bus.rd;
    assign w_ctrl_wr = w_wr && (bus.addr == ADDR_CTRL);

    // Operand bits above WIDTH are not stored
    assign w_unused_ok = ^bus.d_in[BUS_W-1:WIDTH];

    mult_watchdog #(
        .TIMEOUT (TIMEOUT),
        .GUARD   (GUARD)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (r_state == START),
        .i_run       (r_state == WAIT),
        .o_guard_c   (w_guard_c),
        .o_expired_c (w_expired_c)
    );

    // Register file, control FSM, read port and interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_dout   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ie     <= 1'b0;
            r_init   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_init <= 1'b0;

            // Operands are frozen while an operation is in flight
            if (w_wr && !r_busy) begin
                if (bus.addr == ADDR_A) r_a <= bus.d_in[WIDTH-1:0];
                if (bus.addr == ADDR_B) r_b <= bus.d_in[WIDTH-1:0];
            end

            // Flag clears and ie are honoured even while busy; the FSM
            // below assigns later so start and capture take precedence.
            if (w_ctrl_wr) begin
                if (bus.d_in[CTRL_CLR_DONE]) r_done <= 1'b0;
                if (bus.d_in[CTRL_CLR_ERR])  r_err  <= 1'b0;
                r_ie <= bus.d_in[CTRL_IE];
            end

            case (r_state)
                IDLE: begin
                    if (w_ctrl_wr && bus.d_in[CTRL_START]) begin
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_init  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A done seen before GUARD is a stale level from the core
                    if (w_guard_c && mult_done) begin
                        r_state <= CAPTURE;
                    end else if (w_expired_c) begin
                        r_err    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_result <= '0;
                        r_state  <= IDLE;
                    end
                end
                CAPTURE: begin
                    r_result <= mult_pp;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_rd) begin
                case (bus.addr)
                    ADDR_A:    r_dout <= BUS_W'(r_a);
                    ADDR_B:    r_dout <= BUS_W'(r_b);
                    ADDR_CTRL: r_dout <= pack_status(r_ie, r_err, r_done, r_busy);
                    ADDR_RES:  r_dout <= BUS_W'(r_result);
                    default:   r_dout <= '0;
                endcase
            end

            r_irq <= r_ie & (r_done | r_err);
        end
    end

    assign bus.d_out = r_dout;
    assign mult_a    = r_a;
    assign mult_b    = r_b;
    assign mult_init = r_init;
    assign irq       = r_irq;

endmodule

// File: tb/tb_mult_bus_if.sv
// Self-checking bench for mult_bus_if: table of directed operations,
// hand-written corner sequences and randomized operations against a
// behavioural model of the core and of the front end's register rules.
module tb_mult_bus_if;
    import mult_pkg::*;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned GUARD   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [WIDTH-1:0]   mult_a;
    logic [WIDTH-1:0]   mult_b;
    logic               mult_init;
    logic [2*WIDTH-1:0] mult_pp   = '0;
    logic               mult_done = 1'b0;
    logic               irq;

    mult_bus_if_if bus ();

    mult_bus_if #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT),
        .GUARD   (GUARD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_init (mult_init),
        .mult_pp   (mult_pp),
        .mult_done (mult_done),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int init_cnt    = 0;
    int init_cyc    = 0;
    int last_rd_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mult_init) begin
            init_cnt++;
            init_cyc = cyc;
        end
    end

    // Core model: latches the product on init, raises done after core_lat
    // cycles (never if core_hang); core_stale models a leftover done level
    // with a garbage product for the first few cycles after init.
    int          core_lat   = 20;
    int          core_left  = -1;
    int          core_age   = 0;
    int          core_stale = 0;
    bit          core_hang  = 1'b0;
    logic [31:0] core_prod  = '0;

    always @(negedge clk) begin
        if (rst) begin
            mult_done = 1'b0;
            core_left = -1;
        end else if (mult_init) begin
            core_prod = 32'(mult_a) * 32'(mult_b);
            core_left = core_lat;
            core_age  = 0;
            mult_pp   = (core_stale > 0) ? 32'hDEAD_BEEF : core_prod;
            mult_done = (core_stale > 0);
        end else if (core_left > 0) begin
            core_left--;
            core_age++;
            if (core_left == 0 && !core_hang) begin
                mult_done = 1'b1;
                mult_pp   = core_prod;
            end else begin
                mult_done = (core_stale > 0) && (core_age <= core_stale);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
        @(posedge clk);
        #1;
        bus.cs = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        last_rd_cyc = cyc;
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
        @(posedge clk);
        #1;
        d = bus.d_out;
        bus.cs = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        logic [31:0] d = '0;
        for (int i = 0; i < 200; i++) begin
            rd(ADDR_CTRL, d);
            if (!d[STAT_BUSY]) begin
                st = d;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL idle_wait: busy still set after 200 reads, status 0x%08h", d);
        st = d;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int lat,
                          input logic ie, output logic [31:0] res, output logic [31:0] st,
                          output int pulses, output logic irq_s);
        int n0;
        core_lat = lat;
        wr(ADDR_A, 32'(a));
        wr(ADDR_B, 32'(b));
        n0 = init_cnt;
        wr(ADDR_CTRL, 32'({ie, 3'b001}));
        wait_idle(st);
        rd(ADDR_RES, res);
        @(negedge clk);
        irq_s  = irq;
        pulses = init_cnt - n0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
        logic        ie;
        logic [31:0] exp_res;
        logic [31:0] exp_st;
        logic        exp_irq;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [31:0] res, st, d;
        int          pulses, first_err;
        logic        irq_s;

        vt[0] = '{16'd3,      16'd5,      20, 1'b1, 32'd15,        32'h0A, 1'b1};
        vt[1] = '{16'hFFFF,   16'hFFFF,   20, 1'b0, 32'hFFFE_0001, 32'h02, 1'b0};
        vt[2] = '{16'h0000,   16'h1234,    5, 1'b1, 32'h0,         32'h0A, 1'b1};
        vt[3] = '{16'h0001,   16'hFFFF,    1, 1'b0, 32'h0000_FFFF, 32'h02, 1'b0};
        vt[4] = '{16'h1234,   16'h0010,   64, 1'b1, 32'h0001_2340, 32'h0A, 1'b1};
        vt[5] = '{16'h0055,   16'h0066,   65, 1'b1, 32'h0,         32'h0C, 1'b1};
        vt[6] = '{16'h8000,   16'h0002,    3, 1'b0, 32'h0001_0000, 32'h02, 1'b0};

        bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.d_in = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dout",  bus.d_out, 32'h0);
        check("rst_a",     32'(mult_a), 32'h0);
        check("rst_b",     32'(mult_b), 32'h0);
        check("rst_init",  32'(mult_init), 32'h0);
        check("rst_irq",   32'(irq), 32'h0);
        rst = 1'b0;
        rd(ADDR_CTRL, d); check("rst_status", d, 32'h0);
        rd(ADDR_RES, d);  check("rst_result", d, 32'h0);

        // Directed table, including GUARD/TIMEOUT latency boundaries
        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].lat, vt[i].ie, res, st, pulses, irq_s);
            check($sformatf("tbl%0d_result", i), res, vt[i].exp_res);
            check($sformatf("tbl%0d_status", i), st, vt[i].exp_st);
            check($sformatf("tbl%0d_irq", i), 32'(irq_s), 32'(vt[i].exp_irq));
            check($sformatf("tbl%0d_init_pulses", i), 32'(pulses), 32'd1);
        end
        rd(ADDR_A, d); check("readback_a", d, 32'h8000);

        // Done clear also drops the interrupt
        run_op(16'hFFFF, 16'hFFFF, 20, 1'b1, res, st, pulses, irq_s);
        check("ffff_status", st, 32'h0A);
        check("ffff_irq", 32'(irq_s), 32'h1);
        wr(ADDR_CTRL, 32'h2);
        repeat (2) @(negedge clk);
        check("clr_done_irq", 32'(irq), 32'h0);
        rd(ADDR_CTRL, d); check("clr_done_status", d, 32'h0);

        // Busy lockout of operand writes and restart
        core_lat = 30;
        wr(ADDR_A, 32'd6);
        wr(ADDR_B, 32'd7);
        pulses = init_cnt;
        wr(ADDR_CTRL, 32'h1);
        wr(ADDR_A, 32'd7);
        wr(ADDR_CTRL, 32'h1);
        rd(ADDR_A, d); check("busy_a_locked", d, 32'd6);
        wait_idle(st);
        rd(ADDR_RES, res);
        check("busy_result", res, 32'd42);
        check("busy_init_pulses", 32'(init_cnt - pulses), 32'd1);

        // Watchdog timeout with the core never answering
        core_hang = 1'b1;
        first_err = -1;
        wr(ADDR_CTRL, 32'h1);
        for (int i = 0; i < 120; i++) begin
            rd(ADDR_CTRL, d);
            if (d[STAT_ERR]) begin
                first_err = last_rd_cyc;
                st = d;
                break;
            end
        end
        check("timeout_latency", 32'(first_err - init_cyc), 32'(TIMEOUT + 1));
        check("timeout_status", st, 32'h04);
        rd(ADDR_RES, d); check("timeout_result", d, 32'h0);
        wr(ADDR_CTRL, 32'h4);
        rd(ADDR_CTRL, d); check("clr_err_status", d, 32'h0);
        core_hang = 1'b0;

        // Stale done level inside the guard window must be ignored
        core_stale = 2;
        run_op(16'h0021, 16'h0003, 10, 1'b0, res, st, pulses, irq_s);
        check("stale_result", res, 32'h63);
        check("stale_status", st, 32'h02);
        core_stale = 0;

        // Asynchronous reset 5 cycles into WAIT
        core_lat = 30;
        wr(ADDR_A, 32'd9);
        wr(ADDR_B, 32'd9);
        wr(ADDR_CTRL, 32'h9);
        for (int i = 0; i < 20 && !mult_init; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        rd(ADDR_A, d);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_dout", bus.d_out, 32'h0);
        check("arst_a", 32'(mult_a), 32'h0);
        check("arst_b", 32'(mult_b), 32'h0);
        check("arst_init", 32'(mult_init), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd(ADDR_CTRL, d); check("arst_status", d, 32'h0);
        rd(ADDR_RES, d);  check("arst_result", d, 32'h0);
        run_op(16'd4, 16'd5, 10, 1'b1, res, st, pulses, irq_s);
        check("post_rst_result", res, 32'd20);
        check("post_rst_status", st, 32'h0A);

        // Reset while the start pulse is high drops it without a clock edge
        wr(ADDR_CTRL, 32'h1);
        for (int i = 0; i < 20 && !mult_init; i++) @(negedge clk);
        #1 rst = 1'b1;
        #1 check("arst_init_pulse", 32'(mult_init), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized operations against the behavioural model
        for (int n = 0; n < 16; n++) begin
            logic [15:0] ra, rb;
            logic        rie, exp_err;
            int          rlat;
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rie  = 1'($urandom);
            rlat = $urandom_range(1, 72);
            exp_err = (rlat > int'(TIMEOUT));
            run_op(ra, rb, rlat, rie, res, st, pulses, irq_s);
            check($sformatf("rnd%0d_result", n), res,
                  exp_err ? 32'h0 : 32'(ra) * 32'(rb));
            check($sformatf("rnd%0d_status", n), st,
                  32'({rie, exp_err, !exp_err, 1'b0}));
            check($sformatf("rnd%0d_irq", n), 32'(irq_s), 32'(rie));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
